uart_baud_gen_frac: RTL

- Runtime-programmable UART baud generator: the successor to the fixed-divisor generator.
- Produces a 1-clock oversample tick and a 1-clock bit tick, plus a mid-bit tick for the receiver.
- Divisor is integer plus fractional (accumulator dithering), so baud error is far below integer-only division.
- Accepts glitch-free divisor updates over a valid/ready handshake, and a resync pulse that lets the RX realign phase on start-bit detection.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_frac_divider.sv | 71 +++++++
 rtl/uart_baud_gen_frac.sv | 97 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, divisor type and default-divisor helper
// for the fractional UART baud generator.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DIV_INT_W_DEF  = 16;
    localparam int unsigned DIV_FRAC_W_DEF = 4;

    typedef struct packed {
        logic [DIV_INT_W_DEF-1:0]  div_int;
        logic [DIV_FRAC_W_DEF-1:0] div_frac;
    } div_t;

    // Fixed-point clocks per sample tick, with frac_w fractional bits.
    function automatic longint unsigned calc_div(
        input longint unsigned clk_rate,
        input longint unsigned baud,
        input longint unsigned os,
        input longint unsigned frac_w
    );
        return (clk_rate << frac_w) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_frac_divider.sv
// uart_frac_divider: period counter with fractional carry dithering.
// term flags the terminal count this cycle; sample_tick is its registered copy.
module uart_frac_divider
    import uart_pkg::*;
#(
    parameter int unsigned           DIV_INT_W  = DIV_INT_W_DEF,
    parameter int unsigned           DIV_FRAC_W = DIV_FRAC_W_DEF,
    parameter logic [DIV_INT_W-1:0]  RST_INT    = DIV_INT_W'(2),
    parameter logic [DIV_FRAC_W-1:0] RST_FRAC   = DIV_FRAC_W'(0)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  resync,
    input  logic                  load,
    input  logic [DIV_INT_W-1:0]  load_int,
    input  logic [DIV_FRAC_W-1:0] load_frac,
    output logic                  term,
    output logic                  sample_tick
);

    localparam logic [DIV_INT_W-1:0] MIN_INT = DIV_INT_W'(2);
    localparam logic [DIV_INT_W:0]   ONE     = (DIV_INT_W+1)'(1);

    logic [DIV_INT_W-1:0]  div_int;
    logic [DIV_FRAC_W-1:0] div_frac;
    logic [DIV_FRAC_W-1:0] acc;
    logic                  carry;
    logic [DIV_INT_W:0]    cnt;
    logic [DIV_INT_W:0]    last;

    // A period of one clock would make ticks back-to-back.
    function automatic logic [DIV_INT_W-1:0] clamp(
        input logic [DIV_INT_W-1:0] v
    );
        return (v < MIN_INT) ? MIN_INT : v;
    endfunction

    assign last = {1'b0, div_int} + {{DIV_INT_W{1'b0}}, carry} - ONE;
    assign term = enable & ~resync & (cnt == last);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_int     <= clamp(RST_INT);
            div_frac    <= RST_FRAC;
            cnt         <= '0;
            acc         <= '0;
            carry       <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= term;
            if (!enable || resync) begin
                cnt   <= '0;
                acc   <= '0;
                carry <= 1'b0;
            end else if (term) begin
                cnt          <= '0;
                {carry, acc} <= {1'b0, acc} + {1'b0, div_frac};
            end else begin
                cnt <= cnt + ONE;
            end
            if (load) begin
                div_int  <= clamp(load_int);
                div_frac <= load_frac;
                acc      <= '0;
                carry    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac: runtime-programmable fractional baud generator with
// pending-divisor handshake, oversample sub-counter and bit/mid-bit ticks.
module uart_baud_gen_frac
    import uart_pkg::*;
#(
    parameter int unsigned CLK_RATE     = 50000000,
    parameter int unsigned DEFAULT_BAUD = 19200,
    parameter int unsigned OVERSAMPLE   = OVERSAMPLE_DEF,
    parameter int unsigned DIV_INT_W    = DIV_INT_W_DEF,
    parameter int unsigned DIV_FRAC_W   = DIV_FRAC_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  resync,
    input  logic                  cfg_valid,
    input  logic [DIV_INT_W-1:0]  cfg_div_int,
    input  logic [DIV_FRAC_W-1:0] cfg_div_frac,
    output logic                  cfg_ready,
    output logic                  sample_tick,
    output logic                  bit_tick,
    output logic                  mid_tick
);

    localparam longint unsigned DEF_D = calc_div(
        64'(CLK_RATE), 64'(DEFAULT_BAUD),
        64'(OVERSAMPLE), 64'(DIV_FRAC_W));
    localparam logic [DIV_INT_W-1:0]  DEF_INT  = DIV_INT_W'(DEF_D >> DIV_FRAC_W);
    localparam logic [DIV_FRAC_W-1:0] DEF_FRAC = DIV_FRAC_W'(DEF_D);

    localparam int unsigned       SUB_W    = $clog2(OVERSAMPLE);
    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [SUB_W-1:0]  SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SUB_W-1:0]  SUB_ONE  = SUB_W'(1);

    typedef struct packed {
        logic [DIV_INT_W-1:0]  div_int;
        logic [DIV_FRAC_W-1:0] div_frac;
    } cfg_t;

    cfg_t             pend;
    logic             ready;
    logic             term;
    logic             apply;
    logic [SUB_W-1:0] sub;

    assign cfg_ready = ready;
    // Swap only on a period boundary so no running period is cut or stretched.
    assign apply = ~ready & (term | ~enable);

    uart_frac_divider #(
        .DIV_INT_W  (DIV_INT_W),
        .DIV_FRAC_W (DIV_FRAC_W),
        .RST_INT    (DEF_INT),
        .RST_FRAC   (DEF_FRAC)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .resync      (resync),
        .load        (apply),
        .load_int    (pend.div_int),
        .load_frac   (pend.div_frac),
        .term        (term),
        .sample_tick (sample_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b1;
            pend  <= '0;
        end else if (apply) begin
            ready <= 1'b1;
        end else if (cfg_valid && ready) begin
            ready         <= 1'b0;
            pend.div_int  <= cfg_div_int;
            pend.div_frac <= cfg_div_frac;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub      <= '0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
        end else begin
            bit_tick <= term & (sub == SUB_LAST);
            mid_tick <= term & (sub == SUB_MID);
            if (!enable || resync) begin
                sub <= '0;
            end else if (term) begin
                sub <= (sub == SUB_LAST) ? '0 : sub + SUB_ONE;
            end
        end
    end

endmodule
